pipelined_subtractor: RTL and testbench

Parametrised, pipelined ripple-borrow subtractor computing D = A − B − bin over WIDTH bits, split into SEG-bit segments with one pipeline register per segment. It has a valid/ready handshake on both sides and reports borrow-out, overflow, zero and negative flags. A signed/unsigned mode is selected per transaction. It sits in the ALU datapath as the wide-operand successor of the 6-bit combinational subtractor, for widths where a full-width ripple chain would not close timing.

---
 rtl/pipelined_subtractor.sv | 190 +++++++++++++++++++
 tb/tb_pipelined_subtractor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor
// Wide ripple-borrow subtractor D = A - B - bin, resolved SEG bits per stage.
// Each stage register carries the not-yet-resolved operand bits forward, the
// low result bits resolved so far, the borrow into the next segment, the
// operand sign bits, the signed/unsigned mode and a running OR of resolved
// result bits. The last stage register is the output register and holds the
// final difference together with the flags.
// The whole pipeline advances together whenever the output register is empty
// or being drained, so bubbles stay in place and ordering is preserved.
module pipelined_subtractor #(
    parameter int WIDTH = 24,
    parameter int SEG   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             op_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NSEG = WIDTH / SEG;

    // Ripple-borrow over one segment; returns {borrow_out, difference}.
    function automatic logic [SEG:0] sub_seg(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           bi
    );
        logic [SEG-1:0] r;
        logic           c;
        r = '0;
        c = bi;
        for (int i = 0; i < SEG; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (~x[i] & y[i]) | (c & ~(x[i] ^ y[i]));
        end
        return {c, r};
    endfunction

    // Overflow: two's-complement rule in signed mode, borrow-out otherwise.
    function automatic logic ovf_rule(
        input logic op,
        input logic am,
        input logic bm,
        input logic dm,
        input logic bo
    );
        return op ? ((am ^ bm) & (dm ^ am)) : bo;
    endfunction

    // Output register (last pipeline stage).
    logic             out_vld_q;
    logic [WIDTH-1:0] out_d_q;
    logic             out_bout_q;
    logic             out_ovf_q;
    logic             out_zero_q;
    logic             out_neg_q;

    // Global advance: every stage moves when the output slot is free or drains.
    logic adv;
    assign adv      = ~out_vld_q | out_ready;
    assign in_ready = adv;

    assign out_valid = out_vld_q;
    assign d         = out_d_q;
    assign bout      = out_bout_q;
    assign ovf       = out_ovf_q;
    assign zero      = out_zero_q;
    assign neg       = out_neg_q;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO    = k * SEG;
        localparam int SRC_W = WIDTH - LO;

        // Inputs to this stage: operands at stage 0, previous register after.
        logic             src_vld;
        logic [SRC_W-1:0] src_a;
        logic [SRC_W-1:0] src_b;
        logic [WIDTH-1:0] src_d;
        logic             src_brw;
        logic             src_am;
        logic             src_bm;
        logic             src_op;
        logic             src_any;

        logic [SEG:0]     seg_r;
        logic [WIDTH-1:0] nxt_d;
        logic             nxt_any;

        if (k == 0) begin : g_src
            assign src_vld = in_valid & adv;
            assign src_a   = a;
            assign src_b   = b;
            assign src_d   = '0;
            assign src_brw = bin;
            assign src_am  = a[WIDTH-1];
            assign src_bm  = b[WIDTH-1];
            assign src_op  = op_signed;
            assign src_any = 1'b0;
        end else begin : g_src
            assign src_vld = g_stage[k-1].g_reg.vld_q;
            assign src_a   = g_stage[k-1].g_reg.a_q;
            assign src_b   = g_stage[k-1].g_reg.b_q;
            assign src_d   = g_stage[k-1].g_reg.d_q;
            assign src_brw = g_stage[k-1].g_reg.brw_q;
            assign src_am  = g_stage[k-1].g_reg.am_q;
            assign src_bm  = g_stage[k-1].g_reg.bm_q;
            assign src_op  = g_stage[k-1].g_reg.op_q;
            assign src_any = g_stage[k-1].g_reg.any_q;
        end

        // The lowest SRC bits are always the segment this stage resolves.
        assign seg_r   = sub_seg(src_a[SEG-1:0], src_b[SEG-1:0], src_brw);
        assign nxt_any = src_any | (|seg_r[SEG-1:0]);

        // Merge the freshly resolved segment into the partial difference.
        always_comb begin
            nxt_d            = src_d;
            nxt_d[LO +: SEG] = seg_r[SEG-1:0];
        end

        if (k < NSEG - 1) begin : g_reg
            localparam int REM = SRC_W - SEG;

            logic             vld_q;
            logic [REM-1:0]   a_q;
            logic [REM-1:0]   b_q;
            logic [WIDTH-1:0] d_q;
            logic             brw_q;
            logic             am_q;
            logic             bm_q;
            logic             op_q;
            logic             any_q;

            // Stage valid: cleared by reset, shifted on advance.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                end else if (adv) begin
                    vld_q <= src_vld;
                end
            end

            // Stage payload: meaningless while vld_q is low, so no reset.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q   <= src_a[SRC_W-1:SEG];
                    b_q   <= src_b[SRC_W-1:SEG];
                    d_q   <= nxt_d;
                    brw_q <= seg_r[SEG];
                    am_q  <= src_am;
                    bm_q  <= src_bm;
                    op_q  <= src_op;
                    any_q <= nxt_any;
                end
            end
        end else begin : g_out
            // Output register: final segment plus flags; visible, so reset to 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_vld_q  <= 1'b0;
                    out_d_q    <= '0;
                    out_bout_q <= 1'b0;
                    out_ovf_q  <= 1'b0;
                    out_zero_q <= 1'b0;
                    out_neg_q  <= 1'b0;
                end else if (adv) begin
                    out_vld_q  <= src_vld;
                    out_d_q    <= nxt_d;
                    out_bout_q <= seg_r[SEG];
                    out_ovf_q  <= ovf_rule(src_op, src_am, src_bm,
                                           seg_r[SEG-1], seg_r[SEG]);
                    out_zero_q <= ~nxt_any;
                    out_neg_q  <= seg_r[SEG-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor: directed table on WIDTH=24/SEG=6, a stalled
// stream, a mid-flight reset, and random streams on WIDTH=6/SEG=6 and
// WIDTH=32/SEG=8 checked against an arithmetic reference model.
module tb_pipelined_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index 0: 24/6, index 1: 6/6, index 2: 32/8.
    logic        iv   [3];
    logic        ordy [3];
    logic        bin_s[3];
    logic        op_s [3];
    logic [31:0] a_s  [3];
    logic [31:0] b_s  [3];

    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic [23:0] d0;
    logic [5:0]  d1;
    logic [31:0] d2;
    logic        bo0, bo1, bo2, of0, of1, of2, zr0, zr1, zr2, ng0, ng1, ng2;

    int n_vec = 0;
    int n_err = 0;

    pipelined_subtractor #(.WIDTH(24), .SEG(6)) u_w24 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
        .a(a_s[0][23:0]), .b(b_s[0][23:0]), .bin(bin_s[0]), .op_signed(op_s[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .d(d0),
        .bout(bo0), .ovf(of0), .zero(zr0), .neg(ng0));

    pipelined_subtractor #(.WIDTH(6), .SEG(6)) u_w6 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
        .a(a_s[1][5:0]), .b(b_s[1][5:0]), .bin(bin_s[1]), .op_signed(op_s[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .d(d1),
        .bout(bo1), .ovf(of1), .zero(zr1), .neg(ng1));

    pipelined_subtractor #(.WIDTH(32), .SEG(8)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
        .a(a_s[2]), .b(b_s[2]), .bin(bin_s[2]), .op_signed(op_s[2]),
        .out_valid(ov2), .out_ready(ordy[2]), .d(d2),
        .bout(bo2), .ovf(of2), .zero(zr2), .neg(ng2));

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic        bin;
        logic        op;
        logic [23:0] d;
        logic        bo;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  f;
        int          stamp;
    } res_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic int width_of(input int j);
        return (j == 0) ? 24 : (j == 1) ? 6 : 32;
    endfunction

    function automatic int nseg_of(input int j);
        return (j == 1) ? 1 : 4;
    endfunction

    function automatic logic [31:0] get_d(input int j);
        case (j)
            0:       return {8'h0, d0};
            1:       return {26'h0, d1};
            default: return d2;
        endcase
    endfunction

    function automatic logic [3:0] get_f(input int j);
        case (j)
            0:       return {bo0, of0, zr0, ng0};
            1:       return {bo1, of1, zr1, ng1};
            default: return {bo2, of2, zr2, ng2};
        endcase
    endfunction

    function automatic logic get_ov(input int j);
        return (j == 0) ? ov0 : (j == 1) ? ov1 : ov2;
    endfunction

    function automatic logic get_ir(input int j);
        return (j == 0) ? ir0 : (j == 1) ? ir1 : ir2;
    endfunction

    function automatic logic [31:0] rand_op(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return $urandom & m[31:0];
    endfunction

    // Arithmetic reference: {bout, ovf, zero, neg, d}.
    function automatic logic [35:0] ref_sub(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input logic bi,
                                            input logic op);
        logic [63:0] m, ux, uy, diff;
        logic        bo, sx, sy, sd, ov;
        m    = (64'd1 << w) - 64'd1;
        ux   = {32'h0, x} & m;
        uy   = {32'h0, y} & m;
        diff = (ux - uy - {63'h0, bi}) & m;
        bo   = (ux < uy + {63'h0, bi});
        sx   = ux[w-1];
        sy   = uy[w-1];
        sd   = diff[w-1];
        ov   = op ? ((sx ^ sy) & (sd ^ sx)) : bo;
        return {bo, ov, (diff == 64'h0), sd, diff[31:0]};
    endfunction

    // Single isolated transaction on the 24-bit unit with exact latency check.
    task automatic apply_vec(input vec_t v, input string tag);
        int lat;
        iv[0]    = 1'b1;
        a_s[0]   = {8'h0, v.a};
        b_s[0]   = {8'h0, v.b};
        bin_s[0] = v.bin;
        op_s[0]  = v.op;
        ordy[0]  = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, ir0, 1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat   = 0;
        while (!ov0 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_d"}, d0, v.d);
        chk({tag, "_flags"}, {bo0, of0, zr0, ng0}, {v.bo, v.ovf, v.zero, v.neg});
        @(posedge clk); #1;
        chk({tag, "_drained"}, ov0, 0);
    endtask

    // Streaming with scoreboard. mode 0: random valid/ready; mode 1: back-to-back
    // input with out_ready held low for 5 cycles mid-stream.
    task automatic run_stream(input int j, input int ntx, input int mode);
        res_t        q[$];
        res_t        e;
        int          sent, got, cyc, adv_cnt, w, ns, budget;
        logic        acc, rel, adv, stall_prev, exp_ov, ovs, irs;
        logic [31:0] d_prev;
        logic [3:0]  f_prev;
        logic [35:0] r;
        sent = 0; got = 0; cyc = 0; adv_cnt = 0;
        acc = 1'b0; stall_prev = 1'b0; d_prev = '0; f_prev = '0; r = '0;
        w = width_of(j);
        ns = nseg_of(j);
        budget = ntx * 4 + 100;
        while (got < ntx && cyc < budget) begin
            if (mode == 1) ordy[j] = !(cyc >= 6 && cyc < 11);
            else           ordy[j] = ($urandom_range(0, 3) != 0);
            if (!(iv[j] && !acc)) begin
                if (sent < ntx && (mode == 1 || $urandom_range(0, 2) != 0)) begin
                    iv[j]    = 1'b1;
                    a_s[j]   = rand_op(w);
                    b_s[j]   = ($urandom_range(0, 7) == 0) ? a_s[j] : rand_op(w);
                    bin_s[j] = 1'($urandom_range(0, 1));
                    op_s[j]  = 1'($urandom_range(0, 1));
                end else begin
                    iv[j] = 1'b0;
                end
            end
            @(negedge clk);
            ovs = get_ov(j);
            irs = get_ir(j);
            chk("in_ready", irs, !(ovs && !ordy[j]));
            exp_ov = (q.size() > 0) && (adv_cnt - q[0].stamp == ns - 1);
            chk("out_valid", ovs, exp_ov);
            if (ovs && exp_ov) begin
                chk("stream_d", get_d(j), q[0].d);
                chk("stream_flags", get_f(j), q[0].f);
            end
            if (stall_prev) begin
                chk("hold_d", get_d(j), d_prev);
                chk("hold_flags", get_f(j), f_prev);
            end
            acc        = iv[j] && irs;
            rel        = ovs && ordy[j] && exp_ov;
            adv        = irs;
            stall_prev = ovs && !ordy[j];
            d_prev     = get_d(j);
            f_prev     = get_f(j);
            if (acc) r = ref_sub(w, a_s[j], b_s[j], bin_s[j], op_s[j]);
            @(posedge clk);
            if (rel) begin
                void'(q.pop_front());
                got++;
            end
            if (adv) adv_cnt++;
            if (acc) begin
                e.d = r[31:0];
                e.f = r[35:32];
                e.stamp = adv_cnt;
                q.push_back(e);
                sent++;
            end
            #1;
            cyc++;
        end
        iv[j]   = 1'b0;
        ordy[j] = 1'b1;
        chk("stream_complete", got, ntx);
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            iv[j] = 1'b0; ordy[j] = 1'b1; bin_s[j] = 1'b0; op_s[j] = 1'b0;
            a_s[j] = '0; b_s[j] = '0;
        end
        //              a           b          bin   op    d           bo    ovf   zero  neg
        vt[0]  = '{24'h000000, 24'h000001, 1'b0, 1'b0, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[1]  = '{24'h800000, 24'h000001, 1'b0, 1'b1, 24'h7FFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{24'h800000, 24'h000001, 1'b0, 1'b0, 24'h7FFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{24'h123456, 24'h123456, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{24'h000010, 24'h000005, 1'b1, 1'b0, 24'h00000A, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{24'h000000, 24'h000000, 1'b1, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{24'h7FFFFF, 24'hFFFFFF, 1'b0, 1'b1, 24'h800000, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[8]  = '{24'h000040, 24'h000001, 1'b0, 1'b0, 24'h00003F, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{24'hABCDEF, 24'h123456, 1'b0, 1'b1, 24'h999999, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[10] = '{24'h000000, 24'h000000, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        #12;
        chk("reset_out_valid", ov0, 0);
        chk("reset_d", d0, 0);
        chk("reset_flags", {bo0, of0, zr0, ng0}, 0);
        chk("reset_out_valid_w6_w32", {ov1, ov2}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", ir0, 1);

        for (int i = 0; i < 11; i++) begin
            apply_vec(vt[i], $sformatf("vec%0d", i));
        end

        run_stream(0, 8, 1);
        run_stream(0, 300, 0);

        // Reset with three transactions in flight, the oldest already at the output.
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; a_s[0] = '0; b_s[0] = 32'(i + 1); bin_s[0] = 1'b0; op_s[0] = 1'b0;
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        @(posedge clk); #1;
        chk("midrst_pre_out_valid", ov0, 1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", ov0, 0);
        chk("midrst_d", d0, 0);
        chk("midrst_flags", {bo0, of0, zr0, ng0}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", ir0, 1);
        apply_vec(vt[4], "post_rst");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", ov0, 0);
        end

        run_stream(1, 10000, 0);
        run_stream(2, 10000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
